// File: rtl/pwm_if.sv
// PWM engine bus: register-block side (master) drives enable, prescaler,
// reload and compare values; the engine (slave) returns counter and waveforms.
interface pwm_if #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 16
);
  logic                 en;
  logic [PSC_WIDTH-1:0] psc;
  logic [WIDTH-1:0]     arr;
  logic [WIDTH-1:0]     ccr1;
  logic [WIDTH-1:0]     ccr2;
  logic [WIDTH-1:0]     cnt;
  logic                 pwm_ch1;
  logic                 pwm_ch2;
  logic                 update_evt;

  modport master (
    output en, psc, arr, ccr1, ccr2,
    input  cnt, pwm_ch1, pwm_ch2, update_evt
  );

  modport slave (
    input  en, psc, arr, ccr1, ccr2,
    output cnt, pwm_ch1, pwm_ch2, update_evt
  );
endinterface

// File: rtl/pwm_core.sv
// Up-counting timer with prescaler and two edge-aligned PWM channels.
// Ports: clk, rst (async, active-high), bus (pwm_if.slave: en, psc, arr,
// ccr1, ccr2 in; cnt, pwm_ch1, pwm_ch2, update_evt out).
// Macro PWM_PRELOAD_EN: psc/arr/ccr go through shadow registers that are
// committed at wrap or while idle; undefined, the live inputs are used.
module pwm_core #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  pwm_if.slave bus
);

  logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 pwm1_q, pwm1_d;
  logic                 pwm2_q, pwm2_d;
  logic                 upd_q, upd_d;

  logic [PSC_WIDTH-1:0] psc_use;
  logic [WIDTH-1:0]     arr_use;
  logic [WIDTH-1:0]     ccr1_use;
  logic [WIDTH-1:0]     ccr2_use;
  logic                 tick;
  logic                 wrap;

`ifdef PWM_PRELOAD_EN
  logic [PSC_WIDTH-1:0] psc_sh_q, psc_sh_d;
  logic [WIDTH-1:0]     arr_sh_q, arr_sh_d;
  logic [WIDTH-1:0]     ccr1_sh_q, ccr1_sh_d;
  logic [WIDTH-1:0]     ccr2_sh_q, ccr2_sh_d;

  assign psc_use  = psc_sh_q;
  assign arr_use  = arr_sh_q;
  assign ccr1_use = ccr1_sh_q;
  assign ccr2_use = ccr2_sh_q;

  // Idle loads every clock so the first enabled period sees fresh values.
  always_comb begin
    psc_sh_d  = psc_sh_q;
    arr_sh_d  = arr_sh_q;
    ccr1_sh_d = ccr1_sh_q;
    ccr2_sh_d = ccr2_sh_q;
    if (!bus.en || wrap) begin
      psc_sh_d  = bus.psc;
      arr_sh_d  = bus.arr;
      ccr1_sh_d = bus.ccr1;
      ccr2_sh_d = bus.ccr2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_sh_q  <= '0;
      arr_sh_q  <= '0;
      ccr1_sh_q <= '0;
      ccr2_sh_q <= '0;
    end else begin
      psc_sh_q  <= psc_sh_d;
      arr_sh_q  <= arr_sh_d;
      ccr1_sh_q <= ccr1_sh_d;
      ccr2_sh_q <= ccr2_sh_d;
    end
  end
`else
  assign psc_use  = bus.psc;
  assign arr_use  = bus.arr;
  assign ccr1_use = bus.ccr1;
  assign ccr2_use = bus.ccr2;
`endif

  assign tick = (psc_cnt_q == psc_use);
  assign wrap = tick && (cnt_q == arr_use);

  // Compare on the pre-edge count, so outputs trail cnt by one clock.
  always_comb begin
    psc_cnt_d = psc_cnt_q;
    cnt_d     = cnt_q;
    upd_d     = 1'b0;
    pwm1_d    = bus.en && (cnt_q < ccr1_use);
    pwm2_d    = bus.en && (cnt_q < ccr2_use);
    if (!bus.en) begin
      psc_cnt_d = '0;
      cnt_d     = '0;
    end else if (tick) begin
      psc_cnt_d = '0;
      if (wrap) begin
        cnt_d = '0;
        upd_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      psc_cnt_d = psc_cnt_q + PSC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt_q <= '0;
      cnt_q     <= '0;
      pwm1_q    <= 1'b0;
      pwm2_q    <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
      cnt_q     <= cnt_d;
      pwm1_q    <= pwm1_d;
      pwm2_q    <= pwm2_d;
      upd_q     <= upd_d;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.pwm_ch1    = pwm1_q;
  assign bus.pwm_ch2    = pwm2_q;
  assign bus.update_evt = upd_q;

endmodule
